pipeline_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage pipeline of each core.
- Each cycle it decides, for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches, whether to load, hold or insert a bubble.
- Inputs it arbitrates: cache waits, load-use hazards, control redirects resolved in MEM, and halt.
- A small FSM tracks memory-wait and halt-drain. Saturating counters report stall and flush cycles.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/sat_counter.sv | 30 +++
 rtl/pipeline_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
//   pc_sel_t      : next-PC source select driven by the pipeline controller.
//   pctrl_state_t : pipeline controller sequencing state.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    SEQ    = 2'b00,
    BRANCH = 2'b01,
    JUMP   = 2'b10,
    JR     = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DWAIT = 2'b01,
    HALT  = 2'b10
  } pctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance reporting.
//   CLK, nRST : clock, asynchronous active-low reset
//   inc       : count one event this cycle (ignored once all-ones)
//   clr       : synchronous clear, overrides inc
//   count     : current count value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Decides per cycle whether the PC and each pipeline latch loads, holds or
// loads a bubble, and tracks memory-wait / halt-drain sequencing.
//   CLK, nRST              : clock, asynchronous active-low reset
//   ihit, dhit             : fetch / data access completed this cycle
//   exmem_*                : MEM-stage memory op, redirect and halt indications
//   idex_DRen, idex_Rt     : load in EX and its destination register
//   ifid_Rs, ifid_Rt       : source registers of the instruction in ID
//   pc_en, pc_sel          : PC load enable and next-PC source
//   <latch>_en, <latch>_bub: latch load enable; load zero (NOP) when bub=1
//   halt                   : sticky core-halted flag (registered)
//   stall_cnt, flush_cnt   : saturating stall-cycle and redirect counters
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_DRen,
  input  logic             exmem_DWen,
  input  logic             exmem_branch_taken,
  input  logic             exmem_jump,
  input  logic             exmem_jr,
  input  logic             exmem_halt,
  input  logic             idex_DRen,
  input  logic [REG_W-1:0] idex_Rt,
  input  logic [REG_W-1:0] ifid_Rs,
  input  logic [REG_W-1:0] ifid_Rt,
  output logic             pc_en,
  output pc_sel_t          pc_sel,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_bub,
  output logic             idex_bub,
  output logic             exmem_bub,
  output logic             memwb_bub,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pctrl_state_t r_state;
  logic         r_halt;

  logic w_dstall;
  logic w_redirect;
  logic w_luse;
  logic w_in_halt;
  logic w_go_halt;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_dstall   = (exmem_DRen | exmem_DWen) & ~dhit;
  assign w_redirect = exmem_branch_taken | exmem_jump | exmem_jr;
  assign w_luse     = idex_DRen & (idex_Rt != '0) &
                      ((idex_Rt == ifid_Rs) | (idex_Rt == ifid_Rt));
  assign w_in_halt  = (r_state == HALT);
  assign w_go_halt  = ~w_in_halt & exmem_halt & ~w_dstall;

  // RUN and DWAIT share the same priority decode; DWAIT only records that
  // the data access is still outstanding.
  always_comb begin
    pc_en     = 1'b1;
    pc_sel    = SEQ;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    ifid_bub  = 1'b0;
    idex_bub  = 1'b0;
    exmem_bub = 1'b0;
    memwb_bub = 1'b0;
    w_flush_inc = 1'b0;
    if (w_in_halt) begin
      // Drain everything to NOPs and keep the PC frozen.
      pc_en     = 1'b0;
      ifid_bub  = 1'b1;
      idex_bub  = 1'b1;
      exmem_bub = 1'b1;
      memwb_bub = 1'b1;
    end else if (w_dstall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (exmem_halt) begin
      // HALT itself retires into MEM/WB; younger work is squashed.
      pc_en     = 1'b0;
      ifid_bub  = 1'b1;
      idex_bub  = 1'b1;
      exmem_bub = 1'b1;
    end else if (w_redirect) begin
      ifid_bub    = 1'b1;
      idex_bub    = 1'b1;
      exmem_bub   = 1'b1;
      w_flush_inc = 1'b1;
      if (exmem_jr) begin
        pc_sel = JR;
      end else if (exmem_jump) begin
        pc_sel = JUMP;
      end else begin
        pc_sel = BRANCH;
      end
    end else if (w_luse) begin
      // Hold the dependent instruction in ID, feed a bubble into EX.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_bub = 1'b1;
    end else if (!ihit) begin
      pc_en    = 1'b0;
      ifid_bub = 1'b1;
    end
  end

  assign w_stall_inc = ~w_in_halt & ~pc_en & ~w_go_halt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_halt  <= 1'b0;
    end else begin
      unique case (r_state)
        RUN, DWAIT: begin
          if (w_go_halt) begin
            r_state <= HALT;
            r_halt  <= 1'b1;
          end else if (w_dstall) begin
            r_state <= DWAIT;
          end else begin
            r_state <= RUN;
          end
        end
        HALT: r_state <= HALT;
        default: r_state <= RUN;
      endcase
    end
  end

  assign halt = r_halt;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (w_stall_inc),
    .clr  (1'b0),
    .count(stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (w_flush_inc),
    .clr  (1'b0),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: reset-time decode table, directed multi-cycle
// sequences and randomized traffic against a rule-level reference model.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_W = 5;
  localparam int MAXC = (1 << CNT_W) - 1;

  typedef struct packed {
    logic ihit, dhit, dren, dwen, br, j, jr, hlt, idren;
    logic [REG_W-1:0] idrt, rs, rt;
  } in_t;

  // en/bub bit order: {ifid, idex, exmem, memwb}
  typedef struct packed {
    logic       pc_en;
    logic [1:0] sel;
    logic [3:0] en;
    logic [3:0] bub;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic CLK, nRST;
  logic ihit, dhit, exmem_DRen, exmem_DWen, exmem_branch_taken, exmem_jump, exmem_jr;
  logic exmem_halt, idex_DRen;
  logic [REG_W-1:0] idex_Rt, ifid_Rs, ifid_Rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_bub, idex_bub, exmem_bub, memwb_bub, halt;
  pc_sel_t pc_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(
    .CNT_W(CNT_W),
    .REG_W(REG_W)
  ) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .ihit              (ihit),
    .dhit              (dhit),
    .exmem_DRen        (exmem_DRen),
    .exmem_DWen        (exmem_DWen),
    .exmem_branch_taken(exmem_branch_taken),
    .exmem_jump        (exmem_jump),
    .exmem_jr          (exmem_jr),
    .exmem_halt        (exmem_halt),
    .idex_DRen         (idex_DRen),
    .idex_Rt           (idex_Rt),
    .ifid_Rs           (ifid_Rs),
    .ifid_Rt           (ifid_Rt),
    .pc_en             (pc_en),
    .pc_sel            (pc_sel),
    .ifid_en           (ifid_en),
    .idex_en           (idex_en),
    .exmem_en          (exmem_en),
    .memwb_en          (memwb_en),
    .ifid_bub          (ifid_bub),
    .idex_bub          (idex_bub),
    .exmem_bub         (exmem_bub),
    .memwb_bub         (memwb_bub),
    .halt              (halt),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_vec = 0;
  int   n_bad = 0;
  in_t  cur;
  bit   m_halted;
  int   m_stall, m_flush;
  vec_t tbl[14];

  function automatic in_t mk(input logic ih, dh, drn, dwn, b, jj, jjr, h, idr,
                             input int irt, irs, irt2);
    in_t v;
    v.ihit = ih; v.dhit = dh; v.dren = drn; v.dwen = dwn; v.br = b; v.j = jj;
    v.jr = jjr; v.hlt = h; v.idren = idr;
    v.idrt = REG_W'(irt); v.rs = REG_W'(irs); v.rt = REG_W'(irt2);
    return v;
  endfunction

  function automatic out_t mo(input logic pe, input logic [1:0] s,
                              input logic [3:0] e, input logic [3:0] b);
    out_t o;
    o.pc_en = pe; o.sel = s; o.en = e; o.bub = b;
    return o;
  endfunction

  // Reference: what each latch must do, decided from the rules directly.
  function automatic out_t model_out(input in_t v, input bit h);
    bit   dst, redir, lu;
    out_t o;
    dst   = (v.dren | v.dwen) & ~v.dhit;
    redir = v.br | v.j | v.jr;
    lu    = v.idren && (v.idrt != 0) && ((v.idrt == v.rs) || (v.idrt == v.rt));
    o = mo(1'b1, 2'd0, 4'b1111, 4'b0000);
    if (h)               o = mo(1'b0, 2'd0, 4'b1111, 4'b1111);
    else if (dst)        o = mo(1'b0, 2'd0, 4'b0000, 4'b0000);
    else if (v.hlt)      o = mo(1'b0, 2'd0, 4'b1111, 4'b1110);
    else if (redir)      o = mo(1'b1, v.jr ? 2'd3 : (v.j ? 2'd2 : 2'd1), 4'b1111, 4'b1110);
    else if (lu)         o = mo(1'b0, 2'd0, 4'b0111, 4'b0100);
    else if (!v.ihit)    o = mo(1'b0, 2'd0, 4'b1111, 4'b1000);
    return o;
  endfunction

  task automatic model_edge();
    out_t e;
    bit   dst;
    if (!nRST || m_halted) return;
    e   = model_out(cur, 1'b0);
    dst = (cur.dren | cur.dwen) & ~cur.dhit;
    if (cur.hlt && !dst) begin
      m_halted = 1'b1;
    end else begin
      if (!e.pc_en && m_stall < MAXC) m_stall++;
      if (!dst && !cur.hlt && (cur.br | cur.j | cur.jr) && m_flush < MAXC) m_flush++;
    end
  endtask

  task automatic set_in(input in_t v);
    cur = v;
    ihit = v.ihit; dhit = v.dhit; exmem_DRen = v.dren; exmem_DWen = v.dwen;
    exmem_branch_taken = v.br; exmem_jump = v.j; exmem_jr = v.jr; exmem_halt = v.hlt;
    idex_DRen = v.idren; idex_Rt = v.idrt; ifid_Rs = v.rs; ifid_Rt = v.rt;
  endtask

  function automatic out_t act();
    out_t a;
    a.pc_en = pc_en;
    a.sel   = pc_sel;
    a.en    = {ifid_en, idex_en, exmem_en, memwb_en};
    a.bub   = {ifid_bub, idex_bub, exmem_bub, memwb_bub};
    return a;
  endfunction

  task automatic chk_o(input string nm, input out_t want);
    out_t a;
    a = act();
    n_vec++;
    if (a !== want) begin
      n_bad++;
      $display("FAIL %s: got pc_en/sel/en/bub=%b/%b/%b/%b want %b/%b/%b/%b", nm,
               a.pc_en, a.sel, a.en, a.bub, want.pc_en, want.sel, want.en, want.bub);
    end
  endtask

  task automatic chk_v(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_out(input string nm);
    chk_o(nm, model_out(cur, m_halted));
  endtask

  task automatic chk_regs(input string nm);
    chk_v({nm, "_halt"}, int'(halt), int'(m_halted));
    chk_v({nm, "_stall"}, int'(stall_cnt), m_stall);
    chk_v({nm, "_flush"}, int'(flush_cnt), m_flush);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    m_halted = 1'b0; m_stall = 0; m_flush = 0;
    chk_regs("rst");
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  in_t z;
  int  hcnt;

  initial begin
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    m_halted = 1'b0; m_stall = 0; m_flush = 0;
    set_in(z);

    // Decode table applied while reset holds the controller in RUN.
    tbl[0]  = '{mk(0,0,0,0,0,0,0,0,0, 0,0,0), mo(0, 2'd0, 4'b1111, 4'b1000)};
    tbl[1]  = '{mk(1,0,0,0,0,0,0,0,0, 0,0,0), mo(1, 2'd0, 4'b1111, 4'b0000)};
    tbl[2]  = '{mk(1,0,1,0,0,0,0,0,0, 0,0,0), mo(0, 2'd0, 4'b0000, 4'b0000)};
    tbl[3]  = '{mk(1,1,1,0,0,0,0,0,0, 0,0,0), mo(1, 2'd0, 4'b1111, 4'b0000)};
    tbl[4]  = '{mk(0,0,0,1,1,0,0,0,0, 0,0,0), mo(0, 2'd0, 4'b0000, 4'b0000)};
    tbl[5]  = '{mk(1,0,0,0,0,0,0,1,0, 0,0,0), mo(0, 2'd0, 4'b1111, 4'b1110)};
    tbl[6]  = '{mk(1,0,0,0,1,0,0,0,0, 0,0,0), mo(1, 2'd1, 4'b1111, 4'b1110)};
    tbl[7]  = '{mk(0,0,0,0,0,1,0,0,0, 0,0,0), mo(1, 2'd2, 4'b1111, 4'b1110)};
    tbl[8]  = '{mk(1,0,0,0,0,1,1,0,0, 0,0,0), mo(1, 2'd3, 4'b1111, 4'b1110)};
    tbl[9]  = '{mk(1,0,0,0,0,0,0,0,1, 5,5,0), mo(0, 2'd0, 4'b0111, 4'b0100)};
    tbl[10] = '{mk(1,0,0,0,0,0,0,0,1, 0,0,3), mo(1, 2'd0, 4'b1111, 4'b0000)};
    tbl[11] = '{mk(0,0,0,0,0,0,0,0,1, 7,2,7), mo(0, 2'd0, 4'b0111, 4'b0100)};
    tbl[12] = '{mk(1,0,0,0,1,0,0,1,0, 0,0,0), mo(0, 2'd0, 4'b1111, 4'b1110)};
    tbl[13] = '{mk(1,0,0,0,0,0,0,0,0, 4,4,4), mo(1, 2'd0, 4'b1111, 4'b0000)};

    @(negedge CLK);
    for (int k = 0; k < 14; k++) begin
      set_in(tbl[k].i);
      #1;
      chk_o($sformatf("tbl%0d", k), tbl[k].o);
      @(negedge CLK);
    end
    chk_regs("tbl_end");

    // Data stall for three cycles, then the access completes.
    set_in(mk(1,0,1,0,0,0,0,0,0, 0,0,0));
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; chk_out("dwait"); tick();
    end
    set_in(mk(1,1,1,0,0,0,0,0,0, 0,0,0));
    #1; chk_out("dwait_hit");
    chk_v("dwait_hit_en", int'({ifid_en, idex_en, exmem_en, memwb_en}), 15);
    tick();
    chk_v("dwait_stall3", int'(stall_cnt), 3);
    chk_regs("dwait");

    // Load-use, then the same with a zero destination.
    do_reset();
    set_in(mk(1,0,0,0,0,0,0,0,1, 5,5,0));
    #1; chk_out("luse");
    chk_v("luse_pc_en", int'(pc_en), 0);
    tick();
    set_in(mk(1,0,0,0,0,0,0,0,1, 0,5,0));
    #1; chk_out("luse_r0");
    chk_v("luse_r0_pc_en", int'(pc_en), 1);
    tick();

    // Branch beats load-use and a missing fetch.
    set_in(mk(0,0,0,0,1,0,0,0,1, 5,5,0));
    #1; chk_out("br_luse");
    chk_v("br_sel", int'(pc_sel), int'(BRANCH));
    tick();
    chk_v("br_flush", int'(flush_cnt), 1);
    set_in(mk(1,0,0,0,0,1,1,0,0, 0,0,0));
    #1; chk_out("jr_jump");
    chk_v("jr_sel", int'(pc_sel), int'(JR));
    tick();
    chk_regs("redir");

    // Halt arriving behind a data stall.
    do_reset();
    set_in(mk(1,0,1,0,0,0,0,1,0, 0,0,0));
    for (int k = 0; k < 2; k++) begin
      #1; chk_out("halt_dst"); tick();
    end
    set_in(mk(1,1,1,0,0,0,0,1,0, 0,0,0));
    #1; chk_out("halt_go");
    chk_v("halt_pre", int'(halt), 0);
    tick();
    chk_v("halt_set", int'(halt), 1);
    for (int k = 0; k < 6; k++) begin
      set_in(mk(k[0], k[1], $urandom_range(0,1), 0, k[0], 0, 0, 0, 1, 3, 3, 0));
      #1; chk_out("halt_drain");
      chk_v("halt_bub", int'({ifid_bub, idex_bub, exmem_bub, memwb_bub}), 15);
      tick();
    end
    chk_v("halt_frozen", int'(stall_cnt), 2);
    chk_regs("halt");

    // Reset out of HALT.
    do_reset();
    set_in(mk(1,0,0,0,0,0,0,0,0, 0,0,0));
    #1; chk_out("post_halt");
    chk_regs("post_halt");

    // Stall counter saturation.
    set_in(z);
    for (int k = 0; k < 20; k++) tick();
    chk_v("stall_sat", int'(stall_cnt), MAXC);

    // Randomized traffic.
    do_reset();
    hcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      in_t r;
      r.ihit  = ($urandom_range(0,3) != 0);
      r.dhit  = $urandom_range(0,1);
      r.dren  = ($urandom_range(0,3) == 0);
      r.dwen  = ($urandom_range(0,7) == 0);
      r.br    = ($urandom_range(0,7) == 0);
      r.j     = ($urandom_range(0,15) == 0);
      r.jr    = ($urandom_range(0,15) == 0);
      r.hlt   = ($urandom_range(0,59) == 0);
      r.idren = ($urandom_range(0,2) == 0);
      r.idrt  = REG_W'($urandom_range(0,3));
      r.rs    = REG_W'($urandom_range(0,3));
      r.rt    = REG_W'($urandom_range(0,3));
      set_in(r);
      #1; chk_out("rand");
      chk_regs("rand");
      tick();
      hcnt = m_halted ? hcnt + 1 : 0;
      if (hcnt > 8 || $urandom_range(0,299) == 0) begin
        do_reset();
        hcnt = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
